pc_gen: RTL and testbench
=========================

# pc_gen

Program-counter generator for the MiniMIPS32 fetch path, sitting directly upstream of the IF stage. It drives the fetch address and chip-enable that IF checks for alignment, translates, and forwards to instruction memory. It sequences the PC through boot, sequential fetch, stall hold, branch redirect and exception/ERET flush. It can also capture a redirect that arrives while the pipeline is stalled.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: boot fetch address.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `stall_i` input 1: hold the current PC.
- `flush_i` input 1: exception/ERET redirect; overrides everything except reset.
- `flush_pc_i` input 32: target PC when `flush_i`=1.
- `branch_flag_i` input 1: taken branch/jump resolved in ID.
- `branch_target_i` input 32: target PC when `branch_flag_i`=1.
- `pc_o` output 32: fetch address, which feeds IF `addr_i`.
- `ce_o` output 1: fetch chip-enable, which feeds IF `ce_i`.

## Operation
- States:
  - BOOT: `ce_o`=0.
  - RUN: `ce_o`=1, no pending redirect.
  - HOLD: `ce_o`=1, pending redirect captured.
- Reset (`rst`=0, asynchronous): state BOOT, `pc_o`=`RESET_PC`, `ce_o`=0, pending cleared.
- BOOT → RUN on the first rising edge with `rst`=1. `pc_o` stays `RESET_PC`, so the first fetch is at `RESET_PC`.
- Per edge in RUN/HOLD, in priority order:
  1. `flush_i`=1: `pc_o`←`flush_pc_i`; pending cleared; state → RUN. This applies even when `stall_i`=1.
  2. `stall_i`=1 and `branch_flag_i`=1: `pc_o` holds; redirect captured into pending (see Configuration); state → HOLD. A newer capture overwrites an older one.
  3. `stall_i`=1: `pc_o` holds.
  4. `branch_flag_i`=1: `pc_o`←`branch_target_i`; pending cleared. A live branch beats a pending one.
  5. Pending valid: `pc_o`←pending PC; pending cleared; state → RUN.
  6. Otherwise: `pc_o`←`pc_o`+4.
- Arithmetic: `pc_o`+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Targets are passed through unmodified. A misaligned target is not corrected here; IF raises AdEL on it.
- `flush_i` and `branch_flag_i` asserted together: the flush wins and the branch is discarded.

## Timing
- `pc_o` and `ce_o` are registered. A redirect sampled at edge N is visible on `pc_o` immediately after edge N, so there is no bubble.
- A stall sampled at edge N holds `pc_o` through edge N.
- A pending redirect is applied at the first edge where `stall_i`=0 and neither `flush_i` nor `branch_flag_i` is asserted.
- Reset asserted mid-operation: outputs go to their reset values immediately, with no clock required. Any pending redirect is lost.

## Configuration
- `PC_PENDING_REDIRECT_EN` defined:
  - A branch asserted during a stall is captured and replayed once the stall drops.
  - HOLD state and pending registers are present.
- `PC_PENDING_REDIRECT_EN` undefined:
  - No capture; HOLD is unreachable.
  - A branch during a stall is ignored. ID must keep `branch_flag_i`/`branch_target_i` asserted until `stall_i` drops.
  - Flush and sequential behaviour are unchanged.

## Structure
- The shared defines package holds:
  - `RESET_PC` default.
  - `ZeroWord`.
  - `ChipEnable`/`ChipDisable`.
  - State encodings for BOOT/RUN/HOLD.
- Natural sub-module: `pc_redirect_hold`. It owns pending valid/PC capture and clear, and is instantiated only under `PC_PENDING_REDIRECT_EN`.
- `pc_gen` keeps the state machine, priority mux and +4 adder.

## Test plan
- Reset release → `ce_o`: 0 then 1.
  - `pc_o`: 32'hBFC0_0000 for the boot edge and the first fetch, then BFC0_0004, BFC0_0008.
- At `pc_o`=BFC0_0010, `branch_flag_i`=1 with target 32'hBFC0_0100, no stall → `pc_o`=BFC0_0100 after that edge, then BFC0_0104.
- Stall for 3 cycles while `branch_flag_i` pulses once with target 32'h8000_0200 (macro on):
  - `pc_o` holds for 3 cycles.
  - `pc_o`=8000_0200 on the first unstalled edge.
  - With macro off, `pc_o` resumes at held+4.
- `flush_i`=1 with `flush_pc_i`=32'hBFC0_0380, simultaneous with `stall_i`=1, `branch_flag_i`=1 and a pending redirect → `pc_o`=BFC0_0380 and pending cleared.
- Wrap: force `pc_o` to 32'hFFFF_FFFC via branch, then run sequentially → next `pc_o`=32'h0000_0000.
- Assert `rst`=0 mid-HOLD, between clock edges → `pc_o`=BFC0_0000 and `ce_o`=0 immediately, and no replay after release.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the MiniMIPS32 PC generator: boot address, chip-enable
// levels, sequencer state encodings and the sequential-fetch increment.
package pc_gen_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam logic [31:0] ZeroWord         = 32'h0000_0000;
    localparam logic        ChipEnable       = 1'b1;
    localparam logic        ChipDisable      = 1'b0;

    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HOLD = 2'd2
    } pc_state_e;

    // Sequential fetch step; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage : pc_gen_pkg

// File: rtl/pc_redirect_hold.sv
// Pending-redirect register: captures a branch target seen during a stall and
// holds it until the sequencer consumes or discards it.
module pc_redirect_hold
    import pc_gen_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_i,
    input  logic        clear_i,
    input  logic [31:0] target_i,
    output logic        pend_valid_o,
    output logic [31:0] pend_pc_o
);

    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q,    pend_pc_d;

    // Next pending value: a newer capture always overwrites an older one.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        if (capture_i) begin
            pend_valid_d = 1'b1;
            pend_pc_d    = target_i;
        end else if (clear_i) begin
            pend_valid_d = 1'b0;
            pend_pc_d    = pend_pc_q;
        end else begin
            pend_valid_d = pend_valid_q;
            pend_pc_d    = pend_pc_q;
        end
    end

    // Pending state registers; reset drops any captured redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= ZeroWord;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    assign pend_valid_o = pend_valid_q;
    assign pend_pc_o    = pend_pc_q;

endmodule : pc_redirect_hold

// File: rtl/pc_gen.sv
// Program-counter generator feeding the IF stage. Define PC_PENDING_REDIRECT_EN
// to capture branches that arrive during a stall and replay them afterwards.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_o,
    output logic        ce_o
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ce_q;
    logic        pend_valid_s;
    logic [31:0] pend_pc_s;

`ifdef PC_PENDING_REDIRECT_EN
    logic capture_s;
    logic clear_s;

    pc_redirect_hold u_redirect_hold (
        .clk          (clk),
        .rst          (rst),
        .capture_i    (capture_s),
        .clear_i      (clear_s),
        .target_i     (branch_target_i),
        .pend_valid_o (pend_valid_s),
        .pend_pc_o    (pend_pc_s)
    );
`else
    assign pend_valid_s = 1'b0;
    assign pend_pc_s    = ZeroWord;
`endif

    // Redirect priority: flush, stalled branch, stall, live branch, pending, +4.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
`ifdef PC_PENDING_REDIRECT_EN
        capture_s = 1'b0;
        clear_s   = 1'b0;
`endif
        case (state_q)
            PC_BOOT: begin
                // First fetch is at the boot address itself, so no increment here.
                pc_d    = pc_q;
                state_d = PC_RUN;
            end
            PC_RUN, PC_HOLD: begin
                if (flush_i) begin
                    pc_d    = flush_pc_i;
                    state_d = PC_RUN;
`ifdef PC_PENDING_REDIRECT_EN
                    clear_s = 1'b1;
`endif
                end else if (stall_i && branch_flag_i) begin
                    pc_d = pc_q;
`ifdef PC_PENDING_REDIRECT_EN
                    capture_s = 1'b1;
                    state_d   = PC_HOLD;
`else
                    state_d = state_q;
`endif
                end else if (stall_i) begin
                    pc_d    = pc_q;
                    state_d = state_q;
                end else if (branch_flag_i) begin
                    pc_d    = branch_target_i;
                    state_d = PC_RUN;
`ifdef PC_PENDING_REDIRECT_EN
                    clear_s = 1'b1;
`endif
                end else if (pend_valid_s) begin
                    pc_d    = pend_pc_s;
                    state_d = PC_RUN;
`ifdef PC_PENDING_REDIRECT_EN
                    clear_s = 1'b1;
`endif
                end else begin
                    pc_d    = pc_plus4(pc_q);
                    state_d = PC_RUN;
                end
            end
            default: begin
                pc_d    = RESET_PC;
                state_d = PC_BOOT;
            end
        endcase
    end

    // Sequencer state and registered fetch outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PC_BOOT;
            pc_q    <= RESET_PC;
            ce_q    <= ChipDisable;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ce_q    <= (state_d == PC_BOOT) ? ChipDisable : ChipEnable;
        end
    end

    assign pc_o = pc_q;
    assign ce_o = ce_q;

endmodule : pc_gen

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: a reference model pushes expected pc/ce per edge,
// observed outputs are popped and compared one time unit after the edge.
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i, flush_i, branch_flag_i;
    logic [31:0] flush_pc_i, branch_target_i;
    logic [31:0] pc_o;
    logic        ce_o;

    typedef struct packed {
        logic [31:0] pc;
        logic        ce;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model state.
    logic        m_boot;
    logic [31:0] m_pc;
    logic        m_pv;
    logic [31:0] m_pp;

    pc_gen #(.RESET_PC(32'hBFC0_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .flush_pc_i      (flush_pc_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .pc_o            (pc_o),
        .ce_o            (ce_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, want);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_pc   = 32'hBFC0_0000;
        m_pv   = 1'b0;
        m_pp   = 32'h0000_0000;
    endtask

    // Drive one cycle of inputs, predict, wait for the edge, compare.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                        input logic fl, input logic [31:0] fpc);
        exp_t e;
        stall_i = st; branch_flag_i = br; branch_target_i = tgt;
        flush_i = fl; flush_pc_i = fpc;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (fl) begin
            m_pc = fpc; m_pv = 1'b0;
        end else if (st) begin
`ifdef PC_PENDING_REDIRECT_EN
            if (br) begin m_pv = 1'b1; m_pp = tgt; end
`endif
        end else if (br) begin
            m_pc = tgt; m_pv = 1'b0;
        end else if (m_pv) begin
            m_pc = m_pp; m_pv = 1'b0;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        e.pc = m_pc;
        e.ce = ~m_boot;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("pc", pc_o, e.pc);
        chk("ce", {31'd0, ce_o}, {31'd0, e.ce});
        @(negedge clk);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0;
        flush_pc_i = 32'd0; branch_target_i = 32'd0;
        model_reset();
        @(negedge clk);
        chk("reset_pc", pc_o, 32'hBFC0_0000);
        chk("reset_ce", {31'd0, ce_o}, 32'd0);
        rst = 1'b1;

        // Boot edge, first fetch, then sequential up to BFC0_0010.
        idle();
        chk("boot_pc", pc_o, 32'hBFC0_0000);
        idle(); idle(); idle(); idle();
        chk("seq_pc", pc_o, 32'hBFC0_0010);

        step(1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'd0);
        chk("branch_pc", pc_o, 32'hBFC0_0100);
        idle();
        chk("branch_next", pc_o, 32'hBFC0_0104);

        // Three stalled cycles, branch pulses in the first.
        step(1'b1, 1'b1, 32'h8000_0200, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
        chk("stall_hold", pc_o, 32'hBFC0_0104);
        idle();
`ifdef PC_PENDING_REDIRECT_EN
        chk("replay_pc", pc_o, 32'h8000_0200);
`else
        chk("resume_pc", pc_o, 32'hBFC0_0108);
`endif

        // Flush beats stall, branch and a pending redirect.
        step(1'b1, 1'b1, 32'h1234_5670, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h5555_0000, 1'b1, 32'hBFC0_0380);
        chk("flush_pc", pc_o, 32'hBFC0_0380);
        idle();
        chk("flush_clr", pc_o, 32'hBFC0_0384);

        // Newer capture overwrites older; live branch beats pending.
        step(1'b1, 1'b1, 32'hA000_0000, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'hA000_0040, 1'b0, 32'd0);
        idle();
        step(1'b1, 1'b1, 32'hA000_0080, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'hA000_00C0, 1'b0, 32'd0);
        chk("live_wins", pc_o, 32'hA000_00C0);
        idle();

        // Wrap and misaligned pass-through.
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);
        idle();
        chk("wrap_pc", pc_o, 32'h0000_0000);
        step(1'b0, 1'b1, 32'h0000_0003, 1'b0, 32'd0);
        chk("misalign", pc_o, 32'h0000_0003);

        // Random traffic against the model.
        for (int i = 0; i < 60; i++) begin
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom(),
                 ($urandom_range(0, 9) == 0), $urandom());
        end

        // Reset between edges while a redirect is pending.
        step(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h9000_0000, 1'b0, 32'd0);
        stall_i = 1'b0; branch_flag_i = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_pc", pc_o, 32'hBFC0_0000);
        chk("async_ce", {31'd0, ce_o}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle();
        idle();
        chk("no_replay", pc_o, 32'hBFC0_0004);
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_pc_gen
